// File: rtl/neuron_layer12_target_scorer_if.sv
// Signal bundle between the target scorer, its upstream sample source and the 12-neuron layer.
// Upstream handshake: a sample transfers on a rising clock edge where sample_valid && sample_ready.
// sample_ready is high only while the scorer is idle. The upstream keeps the layer inputs stable until pred_valid.
interface neuron_layer12_target_scorer_if #(
   parameter int Z_W   = 8,
   parameter int CNT_W = 16
);
   logic                 sample_valid;
   logic                 sample_ready;
   logic [3:0]           label;
   logic                 train_en;
   logic                 layer_valid;
   logic                 layer_learn;
   logic [11:0][Z_W-1:0] layer_out;
   logic [11:0][Z_W-1:0] expected_out;
   logic                 pred_valid;
   logic [3:0]           pred_class;
   logic                 pred_correct;
   logic [CNT_W-1:0]     sample_count;
   logic [CNT_W-1:0]     correct_count;
   logic [2:0]           state_dbg;

   modport master (
      output sample_valid, label, train_en, layer_out,
      input  sample_ready, layer_valid, layer_learn, expected_out,
             pred_valid, pred_class, pred_correct, sample_count, correct_count, state_dbg
   );

   modport slave (
      input  sample_valid, label, train_en, layer_out,
      output sample_ready, layer_valid, layer_learn, expected_out,
             pred_valid, pred_class, pred_correct, sample_count, correct_count, state_dbg
   );
endinterface

// File: rtl/neuron_layer12_target_scorer.sv
// Controls a 12-neuron layer for one labelled sample: settle, argmax scan, optional learn pulse,
// then reports the prediction and updates the saturating accuracy counters.
module neuron_layer12_target_scorer #(
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16,
   parameter int Z_W    = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   neuron_layer12_target_scorer_if.slave bus
);
   typedef logic [Z_W-1:0] zero2one_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_SCAN   = 3'd2,
      S_LEARN  = 3'd3,
      S_REPORT = 3'd4
   } state_t;

   // The settle counter holds SETTLE-1 down to 0.
   localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'((SETTLE > 0) ? SETTLE - 1 : 0);

   state_t                 state_q, state_d;
   logic [SC_W-1:0]        settle_cnt_q, settle_cnt_d;
   logic [3:0]             idx_q, idx_d;
   zero2one_t              best_q, best_d;
   logic [3:0]             best_idx_q, best_idx_d;
   logic [3:0]             label_l_q, label_l_d;
   logic                   train_l_q, train_l_d;
   zero2one_t [11:0]       expected_q, expected_d;
   logic                   layer_valid_q, layer_valid_d;
   logic                   layer_learn_q, layer_learn_d;
   logic                   pred_valid_q, pred_valid_d;
   logic [3:0]             pred_class_q, pred_class_d;
   logic                   pred_correct_q, pred_correct_d;
   logic [CNT_W-1:0]       sample_count_q, sample_count_d;
   logic [CNT_W-1:0]       correct_count_q, correct_count_d;

   zero2one_t              cur;
   zero2one_t              scan_best;
   logic [3:0]             scan_idx;
   logic                   report;
   logic [3:0]             rep_idx;
   logic                   rep_correct;

   always_comb begin
      state_d         = state_q;
      settle_cnt_d    = settle_cnt_q;
      idx_d           = idx_q;
      best_d          = best_q;
      best_idx_d      = best_idx_q;
      label_l_d       = label_l_q;
      train_l_d       = train_l_q;
      expected_d      = expected_q;
      pred_valid_d    = 1'b0;
      pred_class_d    = pred_class_q;
      pred_correct_d  = pred_correct_q;
      sample_count_d  = sample_count_q;
      correct_count_d = correct_count_q;
      report          = 1'b0;
      rep_idx         = best_idx_q;
      rep_correct     = 1'b0;

      // Strict compare keeps the lowest index on ties; index 0 always seeds the running best.
      cur       = bus.layer_out[idx_q];
      scan_best = best_q;
      scan_idx  = best_idx_q;
      if ((idx_q == 4'd0) || (cur > best_q)) begin
         scan_best = cur;
         scan_idx  = idx_q;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.sample_valid) begin
               label_l_d    = bus.label;
               train_l_d    = bus.train_en;
               settle_cnt_d = SETTLE_LAST;
               idx_d        = 4'd0;
               for (int k = 0; k < 12; k++) begin
                  expected_d[k] = (bus.label == 4'(k)) ? '1 : '0;
               end
               state_d = (SETTLE == 0) ? S_SCAN : S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settle_cnt_q == '0) begin
               state_d = S_SCAN;
            end else begin
               settle_cnt_d = settle_cnt_q - 1'b1;
            end
         end
         S_SCAN: begin
            best_d     = scan_best;
            best_idx_d = scan_idx;
            idx_d      = idx_q + 4'd1;
            if (idx_q == 4'd11) begin
               if (train_l_q && (label_l_q < 4'd12)) begin
                  state_d = S_LEARN;
               end else begin
                  state_d = S_REPORT;
                  report  = 1'b1;
                  rep_idx = scan_idx;
               end
            end
         end
         S_LEARN: begin
            state_d = S_REPORT;
            report  = 1'b1;
         end
         S_REPORT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Result registers load on the edge that enters REPORT so they line up with pred_valid.
      if (report) begin
         rep_correct    = (label_l_q < 4'd12) && (rep_idx == label_l_q);
         pred_valid_d   = 1'b1;
         pred_class_d   = rep_idx;
         pred_correct_d = rep_correct;
         if (sample_count_q != '1) sample_count_d = sample_count_q + 1'b1;
         if (rep_correct && (correct_count_q != '1)) correct_count_d = correct_count_q + 1'b1;
      end

      layer_valid_d = (state_d == S_SETTLE) || (state_d == S_SCAN) || (state_d == S_LEARN);
      layer_learn_d = (state_d == S_LEARN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= S_IDLE;
         settle_cnt_q    <= '0;
         idx_q           <= '0;
         best_q          <= '0;
         best_idx_q      <= '0;
         label_l_q       <= '0;
         train_l_q       <= 1'b0;
         expected_q      <= '0;
         layer_valid_q   <= 1'b0;
         layer_learn_q   <= 1'b0;
         pred_valid_q    <= 1'b0;
         pred_class_q    <= '0;
         pred_correct_q  <= 1'b0;
         sample_count_q  <= '0;
         correct_count_q <= '0;
      end else begin
         state_q         <= state_d;
         settle_cnt_q    <= settle_cnt_d;
         idx_q           <= idx_d;
         best_q          <= best_d;
         best_idx_q      <= best_idx_d;
         label_l_q       <= label_l_d;
         train_l_q       <= train_l_d;
         expected_q      <= expected_d;
         layer_valid_q   <= layer_valid_d;
         layer_learn_q   <= layer_learn_d;
         pred_valid_q    <= pred_valid_d;
         pred_class_q    <= pred_class_d;
         pred_correct_q  <= pred_correct_d;
         sample_count_q  <= sample_count_d;
         correct_count_q <= correct_count_d;
      end
   end

   assign bus.sample_ready  = (state_q == S_IDLE);
   assign bus.layer_valid   = layer_valid_q;
   assign bus.layer_learn   = layer_learn_q;
   assign bus.expected_out  = expected_q;
   assign bus.pred_valid    = pred_valid_q;
   assign bus.pred_class    = pred_class_q;
   assign bus.pred_correct  = pred_correct_q;
   assign bus.sample_count  = sample_count_q;
   assign bus.correct_count = correct_count_q;
   assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_neuron_layer12_target_scorer.sv
// Bench for the target scorer: instance A (SETTLE=2, 16-bit counters) and instance B (SETTLE=0, 2-bit counters).
module tb_neuron_layer12_target_scorer;
   localparam int SETTLE_A = 2;
   localparam int CNT_A    = 16;
   localparam int SETTLE_B = 0;
   localparam int CNT_B    = 2;

   typedef logic [11:0][7:0] vec_t;

   typedef struct packed {
      logic [3:0]  lbl;
      logic        lrn;
      logic [7:0]  lvn;
      logic [7:0]  lat;
      logic [3:0]  cls;
      logic        cor;
      logic [15:0] scnt;
      logic [15:0] ccnt;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic clock;
   logic rst_a;
   logic rst_b;

   neuron_layer12_target_scorer_if #(.Z_W(8), .CNT_W(CNT_A)) bus_a ();
   neuron_layer12_target_scorer_if #(.Z_W(8), .CNT_W(CNT_B)) bus_b ();

   neuron_layer12_target_scorer #(.SETTLE(SETTLE_A), .CNT_W(CNT_A), .Z_W(8)) dut_a (
      .clock (clock),
      .reset (rst_a),
      .bus   (bus_a)
   );

   neuron_layer12_target_scorer #(.SETTLE(SETTLE_B), .CNT_W(CNT_B), .Z_W(8)) dut_b (
      .clock (clock),
      .reset (rst_b),
      .bus   (bus_b)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] exp_b_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc_a = 0;
   int   acc_cyc_b = 0;
   int   lv_cnt_a = 0;
   int   learn_cnt_a = 0;
   int   b_last_pv = 0;
   bit   pending_a = 1'b0;
   bit   b_pv_seen = 1'b0;
   logic [15:0] m_scnt_a = '0;
   logic [15:0] m_ccnt_a = '0;
   logic [1:0]  m_scnt_b = '0;
   logic [1:0]  m_ccnt_b = '0;
   exp_t mon_a;
   exp_t mon_b;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [95:0] onehot(input logic [3:0] l);
      logic [95:0] v;
      v = '0;
      for (int k = 0; k < 12; k++) begin
         if (l == 4'(k)) v[k*8 +: 8] = 8'hFF;
      end
      return v;
   endfunction

   function automatic int argmax(input vec_t lo);
      int bi;
      bi = 0;
      for (int k = 1; k < 12; k++) begin
         if (lo[k] > lo[bi]) bi = k;
      end
      return bi;
   endfunction

   // ---------------- accept detection (shared cycle counter) ----------------
   always @(posedge clock) begin
      if (!rst_a && bus_a.sample_valid && bus_a.sample_ready) begin
         pending_a   = 1'b1;
         acc_cyc_a   = cyc;
         lv_cnt_a    = 0;
         learn_cnt_a = 0;
      end
      if (!rst_b && bus_b.sample_valid && bus_b.sample_ready) begin
         if (b_pv_seen) check_eq("b_accept_gap", 128'(cyc - b_last_pv), 128'(1));
         acc_cyc_b = cyc;
      end
      cyc++;
   end

   // ---------------- monitor A ----------------
   always @(negedge clock) begin
      if (pending_a) check_eq("a_ready_busy", bus_a.sample_ready, 1'b0);
      if (bus_a.layer_valid) lv_cnt_a++;
      if (bus_a.layer_learn) begin
         learn_cnt_a++;
         check_eq("a_learn_stray", bus_a.layer_learn, pending_a);
         if (pending_a && exp_q.size() > 0) begin
            mon_a = exp_q[0];
            check_eq("a_learn_offset", 128'(cyc - acc_cyc_a), 128'(SETTLE_A + 13));
            check_eq("a_learn_expected_out", bus_a.expected_out, onehot(mon_a.lbl));
         end
      end
      if (bus_a.pred_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("a_pred_unexpected", bus_a.pred_valid, 1'b0);
         end else begin
            mon_a = exp_q.pop_front();
            check_eq("a_pred_class", bus_a.pred_class, mon_a.cls);
            check_eq("a_pred_correct", bus_a.pred_correct, mon_a.cor);
            check_eq("a_sample_count", bus_a.sample_count, mon_a.scnt);
            check_eq("a_correct_count", bus_a.correct_count, mon_a.ccnt);
            check_eq("a_latency", 128'(cyc - acc_cyc_a), 128'(mon_a.lat));
            check_eq("a_layer_valid_cycles", 128'(lv_cnt_a), 128'(mon_a.lvn));
            check_eq("a_learn_cycles", 128'(learn_cnt_a), 128'(mon_a.lrn));
            check_eq("a_expected_out_hold", bus_a.expected_out, onehot(mon_a.lbl));
         end
         pending_a = 1'b0;
      end
   end

   // ---------------- monitor B ----------------
   always @(negedge clock) begin
      if (bus_b.pred_valid) begin
         if (exp_b_q.size() == 0) begin
            check_eq("b_pred_unexpected", bus_b.pred_valid, 1'b0);
         end else begin
            mon_b = exp_b_q.pop_front();
            check_eq("b_pred_class", bus_b.pred_class, mon_b.cls);
            check_eq("b_pred_correct", bus_b.pred_correct, mon_b.cor);
            check_eq("b_sample_count", bus_b.sample_count, mon_b.scnt);
            check_eq("b_correct_count", bus_b.correct_count, mon_b.ccnt);
            check_eq("b_latency", 128'(cyc - acc_cyc_b), 128'(mon_b.lat));
         end
         b_pv_seen = 1'b1;
         b_last_pv = cyc;
      end
   end

   // ---------------- drivers ----------------
   task automatic drive_a(input vec_t lo, input logic [3:0] lbl, input logic trn);
      exp_t e;
      int   bi;
      int   n;
      logic cor;
      logic lrn;
      bi  = argmax(lo);
      cor = (lbl < 4'd12) && (4'(bi) == lbl);
      lrn = trn && (lbl < 4'd12);
      if (m_scnt_a != 16'hFFFF) m_scnt_a = m_scnt_a + 16'd1;
      if (cor && m_ccnt_a != 16'hFFFF) m_ccnt_a = m_ccnt_a + 16'd1;
      e.lbl  = lbl;
      e.lrn  = lrn;
      e.lvn  = 8'(SETTLE_A + 12 + int'(lrn));
      e.lat  = 8'(SETTLE_A + 13 + int'(lrn));
      e.cls  = 4'(bi);
      e.cor  = cor;
      e.scnt = m_scnt_a;
      e.ccnt = m_ccnt_a;
      exp_q.push_back(e);

      bus_a.layer_out    = lo;
      bus_a.label        = lbl;
      bus_a.train_en     = trn;
      bus_a.sample_valid = 1'b1;
      n = 0;
      while (!bus_a.sample_ready && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (n >= 40) check_eq("a_ready_timeout", bus_a.sample_ready, 1'b1);
      @(posedge clock);
      @(negedge clock);
      bus_a.sample_valid = 1'b0;
      bus_a.label        = 4'($urandom_range(0, 15));
      bus_a.train_en     = 1'($urandom_range(0, 1));
      n = 0;
      while (!bus_a.pred_valid && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (n >= 40) check_eq("a_pred_timeout", bus_a.pred_valid, 1'b1);
      @(negedge clock);
   endtask

   // ---------------- stimulus ----------------
   vec_t pat1;
   vec_t pat_b;
   vec_t pat_r;
   vec_t flat40;
   int   n_pv;
   int   n_wait;
   exp_t eb;

   initial begin
      for (int k = 0; k < 12; k++) begin
         pat1[k]   = 8'(k * 16);
         pat_b[k]  = 8'(k * 8);
         flat40[k] = 8'h40;
      end
      pat1[7]  = 8'hFF;
      pat_b[5] = 8'hF0;

      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.sample_valid = 1'b1;
      bus_a.label        = 4'd7;
      bus_a.train_en     = 1'b1;
      bus_a.layer_out    = pat1;
      bus_b.sample_valid = 1'b0;
      bus_b.label        = 4'd0;
      bus_b.train_en     = 1'b0;
      bus_b.layer_out    = '0;
      repeat (3) @(negedge clock);

      // reset state, with sample_valid asserted during reset
      check_eq("rst_sample_ready", bus_a.sample_ready, 1'b1);
      check_eq("rst_layer_valid", bus_a.layer_valid, 1'b0);
      check_eq("rst_layer_learn", bus_a.layer_learn, 1'b0);
      check_eq("rst_pred_valid", bus_a.pred_valid, 1'b0);
      check_eq("rst_pred_class", bus_a.pred_class, 4'd0);
      check_eq("rst_counts", {bus_a.sample_count, bus_a.correct_count}, 32'd0);
      check_eq("rst_expected_out", bus_a.expected_out, 96'd0);
      check_eq("rst_state", bus_a.state_dbg, 3'd0);
      bus_a.sample_valid = 1'b0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clock);
      check_eq("post_rst_idle", bus_a.state_dbg, 3'd0);
      check_eq("post_rst_layer_valid", bus_a.layer_valid, 1'b0);

      // B: five back-to-back correct samples, sample_valid held, 2-bit saturating counters
      for (int i = 1; i <= 5; i++) begin
         if (m_scnt_b != 2'b11) m_scnt_b = m_scnt_b + 2'd1;
         if (m_ccnt_b != 2'b11) m_ccnt_b = m_ccnt_b + 2'd1;
         eb.lbl  = 4'd5;
         eb.lrn  = 1'b1;
         eb.lvn  = 8'(SETTLE_B + 13);
         eb.lat  = 8'(SETTLE_B + 14);
         eb.cls  = 4'd5;
         eb.cor  = 1'b1;
         eb.scnt = 16'(m_scnt_b);
         eb.ccnt = 16'(m_ccnt_b);
         exp_b_q.push_back(eb);
      end
      bus_b.layer_out    = pat_b;
      bus_b.label        = 4'd5;
      bus_b.train_en     = 1'b1;
      bus_b.sample_valid = 1'b1;
      n_pv   = 0;
      n_wait = 0;
      while (n_pv < 5 && n_wait < 200) begin
         @(negedge clock);
         n_wait++;
         if (bus_b.pred_valid) n_pv++;
      end
      bus_b.sample_valid = 1'b0;
      if (n_wait >= 200) check_eq("b_pred_timeout", bus_b.pred_valid, 1'b1);
      repeat (3) @(negedge clock);

      // A: directed samples
      drive_a(pat1, 4'd7, 1'b1);
      drive_a(flat40, 4'd3, 1'b1);
      drive_a(pat1, 4'd7, 1'b0);
      drive_a(pat1, 4'd13, 1'b1);
      drive_a(pat1, 4'd11, 1'b1);

      // A: random samples with frequent ties
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 12; k++) pat_r[k] = 8'($urandom_range(0, 3) * 64);
         drive_a(pat_r, 4'($urandom_range(0, 13)), 1'($urandom_range(0, 1)));
      end

      // A: reset in the middle of SCAN aborts the sample
      bus_a.layer_out    = pat1;
      bus_a.label        = 4'd7;
      bus_a.train_en     = 1'b1;
      bus_a.sample_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus_a.sample_valid = 1'b0;
      repeat (5) @(negedge clock);
      check_eq("abort_in_scan", bus_a.state_dbg, 3'd2);
      rst_a = 1'b1;
      exp_q.delete();
      pending_a = 1'b0;
      m_scnt_a  = '0;
      m_ccnt_a  = '0;
      @(negedge clock);
      rst_a = 1'b0;
      check_eq("abort_sample_ready", bus_a.sample_ready, 1'b1);
      check_eq("abort_state", bus_a.state_dbg, 3'd0);
      check_eq("abort_counts", {bus_a.sample_count, bus_a.correct_count}, 32'd0);
      check_eq("abort_expected_out", bus_a.expected_out, 96'd0);
      check_eq("abort_layer_valid", bus_a.layer_valid, 1'b0);
      repeat (25) @(negedge clock);
      drive_a(pat1, 4'd7, 1'b1);

      repeat (4) @(negedge clock);
      check_eq("a_queue_empty", 128'(exp_q.size()), 128'(0));
      check_eq("b_queue_empty", 128'(exp_b_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
